// File: rtl/ntt_result_reader_pkg.sv
// rtl/ntt_result_reader_pkg.sv - shared NTT constants, memory region encodings and reader FSM states
package ntt_result_reader_pkg;

    localparam int COEF_W    = 16;
    localparam int LANES     = 16;
    localparam int NUM_WORDS = 64;

    // 9-bit coefficient memory address = {region, word}
    localparam logic [1:0] REGION_A      = 2'b00;
    localparam logic [1:0] REGION_B      = 2'b01;
    localparam logic [1:0] REGION_RESULT = 2'b10;

    localparam logic [8:0] RBASE = {REGION_RESULT, 7'd0};

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } reader_state_t;

endpackage

// File: rtl/ntt_word_fifo2.sv
// rtl/ntt_word_fifo2.sv - two-entry word FIFO with count, simultaneous push/pop and reset clear
// Ports: clk, reset (sync, active-high), push/push_data write side,
//        pop read side, head = oldest entry, count = occupancy 0..2.
module ntt_word_fifo2 #(
    parameter int W = 256
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [1:0]   count
);

    logic [W-1:0] slot1;

    // slot 0 (head) is always the oldest entry; a pop shifts slot 1 down
    always_ff @(posedge clk) begin
        if (reset) begin
            head  <= '0;
            slot1 <= '0;
            count <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head  <= push_data;
                    else               slot1 <= push_data;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= slot1;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= push_data;
                    end else begin
                        head  <= slot1;
                        slot1 <= push_data;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            assert (!(push && !pop && count == 2'd2));
            assert (!(pop && count == 2'd0));
        end
    end

endmodule

// File: rtl/ntt_result_reader.sv
// rtl/ntt_result_reader.sv - unloads the NTT result region and streams it one coefficient per beat
// Ports: clk, reset (sync, active-high), start (unload request),
//        raddr/ren/rdata coefficient memory read port (1-cycle latency),
//        out_data/out_valid/out_ready/out_last coefficient stream,
//        busy (unload in progress), done (pulse after final beat).
module ntt_result_reader
    import ntt_result_reader_pkg::*;
#(
    parameter int         COEF_W    = ntt_result_reader_pkg::COEF_W,
    parameter int         LANES     = ntt_result_reader_pkg::LANES,
    parameter int         NUM_WORDS = ntt_result_reader_pkg::NUM_WORDS,
    parameter logic [8:0] RBASE     = ntt_result_reader_pkg::RBASE
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    output logic [8:0]                raddr,
    output logic                      ren,
    input  logic [COEF_W*LANES-1:0]   rdata,
    output logic [COEF_W-1:0]         out_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      out_last,
    output logic                      busy,
    output logic                      done
);

    localparam int WC_W = $clog2(NUM_WORDS + 1);
    localparam int LI_W = $clog2(LANES);

    generate
        if (RBASE[8:7] != REGION_RESULT || (int'(RBASE[6:0]) + NUM_WORDS - 1) > 127) begin : g_bad_rbase
            $error("result words must lie inside the result region");
        end
    endgenerate

    reader_state_t             state;
    logic [WC_W-1:0]           wc;      // words issued
    logic [WC_W-1:0]           oc;      // words fully streamed
    logic [LI_W-1:0]           li;      // lane within head word
    logic                      rvalid;  // rdata holds a returning word this cycle
    logic [1:0]                fifo_count;
    logic [COEF_W*LANES-1:0]   head;
    logic                      hs;
    logic                      pop;
    logic                      credit;

    ntt_word_fifo2 #(.W(COEF_W*LANES)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (rvalid),
        .push_data (rdata),
        .pop       (pop),
        .head      (head),
        .count     (fifo_count)
    );

    // Stream comes straight off the FIFO head: it only changes on a handshake,
    // so data stays stable under backpressure and a pop+push keeps beats back-to-back.
    assign out_valid = (fifo_count != 2'd0);
    assign out_data  = out_valid ? head[li*COEF_W +: COEF_W] : '0;
    assign out_last  = out_valid && (oc == WC_W'(NUM_WORDS - 1)) && (li == LI_W'(LANES - 1));
    assign hs        = out_valid && out_ready;
    assign pop       = hs && (li == LI_W'(LANES - 1));

    // Words buffered plus words still in flight (issued now, or returning now)
    // never exceed the two FIFO slots.
    assign credit = (3'(fifo_count) + 3'(ren) + 3'(rvalid)) < 3'd2;

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            wc     <= '0;
            oc     <= '0;
            li     <= '0;
            rvalid <= 1'b0;
            raddr  <= 9'd0;
            ren    <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            rvalid <= ren;
            done   <= 1'b0;
            if (hs) li <= pop ? '0 : li + LI_W'(1);
            if (pop) oc <= oc + WC_W'(1);

            case (state)
                ST_IDLE: begin
                    ren <= 1'b0;
                    if (start) begin
                        // first read goes out immediately so it lands in the next cycle
                        busy  <= 1'b1;
                        ren   <= 1'b1;
                        raddr <= RBASE;
                        wc    <= WC_W'(1);
                        oc    <= '0;
                        li    <= '0;
                        state <= (NUM_WORDS == 1) ? ST_DRAIN : ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    if (credit) begin
                        ren   <= 1'b1;
                        raddr <= RBASE + 9'(wc);
                        wc    <= wc + WC_W'(1);
                        if (wc == WC_W'(NUM_WORDS - 1)) state <= ST_DRAIN;
                    end else begin
                        ren <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    ren <= 1'b0;
                    if (hs && out_last) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
